// File: rtl/pipe_ctrl_regs.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_regs
// Pipeline control-register chain D -> E -> M -> WB for the 5-stage core.
// Sits at the consumer end of the hazard unit: it applies the stall/flush
// commands to the stage registers and feeds back the register keys,
// write-enables and load flag that the hazard unit inspects. Also keeps a
// sticky protocol-error flag and stall/flush/retire performance counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   f_in_*                   instruction tuple presented at the F/D boundary
//   hu_in_*                  hazard-unit stall/flush commands
//   pcr_out_fetch_en         combinational inverse of hu_in_stall_f_en
//   d_out_*, e_out_*         D/E stage keys (ungated) and E load flag
//   m_out_*, wb_out_*        M/WB destination keys and valid-gated write enables
//   pcr_out_proto_err        sticky illegal stall/flush combination flag
//   pcr_out_*_cnt            wrapping stall / flush / retire counters
// ---------------------------------------------------------------------------
module pipe_ctrl_regs #(
  parameter int unsigned KEY_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_in_valid,
  input  logic [KEY_W-1:0] f_in_r1_key,
  input  logic [KEY_W-1:0] f_in_r2_key,
  input  logic [KEY_W-1:0] f_in_rd_key,
  input  logic             f_in_rd_we,
  input  logic             f_in_is_load,
  input  logic             hu_in_stall_f_en,
  input  logic             hu_in_stall_d_en,
  input  logic             hu_in_flush_e_en,
  input  logic             hu_in_flush_d_en,
  output logic             pcr_out_fetch_en,
  output logic [KEY_W-1:0] d_out_r1_key,
  output logic [KEY_W-1:0] d_out_r2_key,
  output logic [KEY_W-1:0] e_out_r1_key,
  output logic [KEY_W-1:0] e_out_r2_key,
  output logic [KEY_W-1:0] e_out_rd_key,
  output logic             e_out_rd_is_load_en,
  output logic [KEY_W-1:0] m_out_rd_key,
  output logic             m_out_rd_we,
  output logic [KEY_W-1:0] wb_out_rd_key,
  output logic             wb_out_rd_we,
  output logic             pcr_out_proto_err,
  output logic [CNT_W-1:0] pcr_out_stall_cnt,
  output logic [CNT_W-1:0] pcr_out_flush_cnt,
  output logic [CNT_W-1:0] pcr_out_retire_cnt
);

  // Full tuple carried by the D and E stages.
  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] r1;
    logic [KEY_W-1:0] r2;
    logic [KEY_W-1:0] rd;
    logic             rd_we;
    logic             is_load;
  } stage_t;

  // Past E only the destination side is ever observed, so M and WB keep just that.
  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] rd;
    logic             rd_we;
  } dst_t;

  stage_t d_q, e_q;
  dst_t   m_q, wb_q;
  stage_t d_nxt, e_nxt, f_tuple;
  dst_t   m_nxt;

  logic             proto_err_q;
  logic             illegal_c;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;

  // Fetch enable is the only combinational output.
  assign pcr_out_fetch_en = ~hu_in_stall_f_en;

  // Incoming tuple; invalid instructions become bubbles and x0 never gets a write-enable.
  always_comb begin
    f_tuple = '0;
    if (f_in_valid) begin
      f_tuple.valid   = 1'b1;
      f_tuple.r1      = f_in_r1_key;
      f_tuple.r2      = f_in_r2_key;
      f_tuple.rd      = f_in_rd_key;
      f_tuple.rd_we   = f_in_rd_we & (f_in_rd_key != '0);
      f_tuple.is_load = f_in_is_load;
    end
  end

  // Next-state for the stage registers; flush outranks stall in D.
  always_comb begin
    d_nxt = f_tuple;
    if (hu_in_flush_d_en) begin
      d_nxt = '0;
    end else if (hu_in_stall_d_en) begin
      d_nxt = d_q;
    end

    e_nxt = d_q;
    if (hu_in_flush_e_en) begin
      e_nxt = '0;
    end

    m_nxt       = '0;
    m_nxt.valid = e_q.valid;
    m_nxt.rd    = e_q.rd;
    m_nxt.rd_we = e_q.rd_we;
  end

  // Stall/flush combinations the hazard unit must never issue.
  always_comb begin
    illegal_c = (hu_in_stall_d_en & ~hu_in_stall_f_en) |
                (hu_in_stall_f_en & ~hu_in_stall_d_en) |
                (hu_in_stall_d_en & ~hu_in_flush_e_en) |
                (hu_in_flush_d_en & ~hu_in_flush_e_en);
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= '0;
      e_q  <= '0;
      m_q  <= '0;
      wb_q <= '0;
    end else begin
      d_q  <= d_nxt;
      e_q  <= e_nxt;
      m_q  <= m_nxt;
      wb_q <= m_q;
    end
  end

  // Sticky protocol error and wrapping performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q  <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      proto_err_q  <= proto_err_q | illegal_c;
      stall_cnt_q  <= stall_cnt_q + CNT_W'(hu_in_stall_d_en);
      flush_cnt_q  <= flush_cnt_q + CNT_W'(hu_in_flush_d_en);
      retire_cnt_q <= retire_cnt_q + CNT_W'(wb_q.valid);
    end
  end

  // Keys pass through ungated; enables are qualified by the stage valid bit.
  assign d_out_r1_key        = d_q.r1;
  assign d_out_r2_key        = d_q.r2;
  assign e_out_r1_key        = e_q.r1;
  assign e_out_r2_key        = e_q.r2;
  assign e_out_rd_key        = e_q.rd;
  assign e_out_rd_is_load_en = e_q.valid & e_q.is_load;
  assign m_out_rd_key        = m_q.rd;
  assign m_out_rd_we         = m_q.valid & m_q.rd_we;
  assign wb_out_rd_key       = wb_q.rd;
  assign wb_out_rd_we        = wb_q.valid & wb_q.rd_we;
  assign pcr_out_proto_err   = proto_err_q;
  assign pcr_out_stall_cnt   = stall_cnt_q;
  assign pcr_out_flush_cnt   = flush_cnt_q;
  assign pcr_out_retire_cnt  = retire_cnt_q;

endmodule
